// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel-clock raster generator with a colour/sync alignment pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int RGB_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [15:0] frameCount,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] c_V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_sof;
  logic [15:0] r_frame_cnt;

  logic        w_h_wrap;
  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_sof_next;

  logic        w_active;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_act_d;
  logic        w_hs_d;
  logic        w_vs_d;

  // Next counter values are computed up front so startOfFrame and frameCount
  // can be registered on the same edge that moves the raster onto (0, V_ACTIVE).
  always_comb begin
    w_h_wrap = (r_hcount == c_H_LAST);
    w_h_next = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_v_next = r_vcount;
    if (w_h_wrap) begin
      w_v_next = (r_vcount == c_V_LAST) ? 11'd0 : r_vcount + 11'd1;
    end
    w_sof_next = (w_h_next == 11'd0) && (w_v_next == c_V_ACT);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hcount    <= 11'd0;
      r_vcount    <= 11'd0;
      r_sof       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_sof    <= w_sof_next;
      if (w_sof_next) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign pixelX       = r_hcount;
  assign pixelY       = r_vcount;
  assign startOfFrame = r_sof;
  assign frameCount   = r_frame_cnt;

  assign w_active = (r_hcount < c_H_ACT) && (r_vcount < c_V_ACT);
  assign w_hs_raw = !((r_hcount >= c_HS_START) && (r_hcount < c_HS_END));
  assign w_vs_raw = !((r_vcount >= c_VS_START) && (r_vcount < c_VS_END));

  // Timing flags wait here for the drawing pipeline to deliver the matching colour.
  generate
    if (RGB_LATENCY == 0) begin : g_no_delay
      assign w_act_d = w_active;
      assign w_hs_d  = w_hs_raw;
      assign w_vs_d  = w_vs_raw;
    end else begin : g_delay
      logic [RGB_LATENCY-1:0] r_act_sr;
      logic [RGB_LATENCY-1:0] r_hs_sr;
      logic [RGB_LATENCY-1:0] r_vs_sr;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          r_act_sr <= '0;
          r_hs_sr  <= '1;
          r_vs_sr  <= '1;
        end else begin
          r_act_sr[0] <= w_active;
          r_hs_sr[0]  <= w_hs_raw;
          r_vs_sr[0]  <= w_vs_raw;
          for (int i = 1; i < RGB_LATENCY; i++) begin
            r_act_sr[i] <= r_act_sr[i-1];
            r_hs_sr[i]  <= r_hs_sr[i-1];
            r_vs_sr[i]  <= r_vs_sr[i-1];
          end
        end
      end

      assign w_act_d = r_act_sr[RGB_LATENCY-1];
      assign w_hs_d  = r_hs_sr[RGB_LATENCY-1];
      assign w_vs_d  = r_vs_sr[RGB_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 4'd0;
      VGA_G       <= 4'd0;
      VGA_B       <= 4'd0;
    end else begin
      VGA_HS      <= w_hs_d;
      VGA_VS      <= w_vs_d;
      VGA_BLANK_N <= w_act_d;
      // MSB replication stretches 3/2-bit channels to full-scale 4-bit codes.
      VGA_R       <= w_act_d ? {RGB_in[7:5], RGB_in[7]}   : 4'd0;
      VGA_G       <= w_act_d ? {RGB_in[4:2], RGB_in[4]}   : 4'd0;
      VGA_B       <= w_act_d ? {RGB_in[1:0], RGB_in[1:0]} : 4'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen on a reduced raster, latency 0 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int HBP = 3;
  localparam int VA  = 10;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;   // 25
  localparam int VT  = VA + VFP + VSW + VBP;   // 17
  localparam int FT  = HT * VT;                // 425
  localparam int L1  = 3;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bn;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_t;

  typedef struct packed {
    logic [10:0] px;
    logic [10:0] py;
    logic        sof;
    logic [15:0] fc;
    vga_t        v0;
    vga_t        v1;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  rgb0;
  logic [7:0]  rgb1;

  logic [10:0] px0, py0, px1, py1;
  logic        sof0, sof1;
  logic [15:0] fc0, fc1;
  logic        hs0, vs0, bn0, hs1, vs1, bn1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .RGB_LATENCY(0)
  ) dut0 (
    .clk(clk), .resetN(resetN), .RGB_in(rgb0),
    .pixelX(px0), .pixelY(py0), .startOfFrame(sof0), .frameCount(fc0),
    .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .RGB_LATENCY(L1)
  ) dut1 (
    .clk(clk), .resetN(resetN), .RGB_in(rgb1),
    .pixelX(px1), .pixelY(py1), .startOfFrame(sof1), .frameCount(fc1),
    .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bn1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sq[$];
  vga_t dq0[$];
  vga_t dq1[$];
  logic [7:0] ch[$];
  event ev_cyc;

  int          hx;
  int          vy;
  logic [15:0] fc;

  function automatic logic [7:0] col(int x, int y);
    return 8'((x * 37 + y * 5) & 255);
  endfunction

  function automatic vga_t rst_v();
    vga_t v;
    v = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, r: 4'd0, g: 4'd0, b: 4'd0};
    return v;
  endfunction

  function automatic vga_t e_of(int x, int y);
    vga_t       v;
    logic [7:0] c;
    logic       act;
    c    = col(x, y);
    act  = (x < HA) && (y < VA);
    v.hs = !((x >= HA + HFP) && (x < HA + HFP + HSW));
    v.vs = !((y >= VA + VFP) && (y < VA + VFP + VSW));
    v.bn = act;
    v.r  = act ? {c[7:5], c[7]}   : 4'd0;
    v.g  = act ? {c[4:2], c[4]}   : 4'd0;
    v.b  = act ? {c[1:0], c[1:0]} : 4'd0;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at (%0d,%0d) t=%0t: got %0h expected %0h", nm, hx, vy, $time, act, exp_v);
    end
  endtask

  task automatic chk_v(string tag, vga_t a, vga_t e);
    chk({tag, ".HS"}, 32'(a.hs), 32'(e.hs));
    chk({tag, ".VS"}, 32'(a.vs), 32'(e.vs));
    chk({tag, ".BLANK_N"}, 32'(a.bn), 32'(e.bn));
    chk({tag, ".R"}, 32'(a.r), 32'(e.r));
    chk({tag, ".G"}, 32'(a.g), 32'(e.g));
    chk({tag, ".B"}, 32'(a.b), 32'(e.b));
  endtask

  // Monitor: pops one expectation per presented output cycle and compares.
  initial begin
    exp_t e;
    vga_t a0, a1;
    forever begin
      @(ev_cyc);
      if (sq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard empty at t=%0t", $time);
      end else begin
        e  = sq.pop_front();
        a0 = '{hs: hs0, vs: vs0, bn: bn0, r: r0, g: g0, b: b0};
        a1 = '{hs: hs1, vs: vs1, bn: bn1, r: r1, g: g1, b: b1};
        chk("d0.pixelX", 32'(px0), 32'(e.px));
        chk("d0.pixelY", 32'(py0), 32'(e.py));
        chk("d0.startOfFrame", 32'(sof0), 32'(e.sof));
        chk("d0.frameCount", 32'(fc0), 32'(e.fc));
        chk("d1.pixelX", 32'(px1), 32'(e.px));
        chk("d1.pixelY", 32'(py1), 32'(e.py));
        chk("d1.startOfFrame", 32'(sof1), 32'(e.sof));
        chk("d1.frameCount", 32'(fc1), 32'(e.fc));
        chk_v("d0", a0, e.v0);
        chk_v("d1", a1, e.v1);
      end
    end
  end

  // Expectation for a DUT held in reset: everything at its reset value.
  task automatic push_reset_exp();
    exp_t e;
    e = '{px: 11'd0, py: 11'd0, sof: 1'b0, fc: 16'd0, v0: rst_v(), v1: rst_v()};
    sq.push_back(e);
    -> ev_cyc;
  endtask

  task automatic start_after_reset();
    hx = 0;
    vy = 0;
    fc = 16'd0;
    dq0.delete();
    dq1.delete();
    ch.delete();
    dq0.push_back(rst_v());
    for (int i = 0; i < L1 + 1; i++) dq1.push_back(rst_v());
    for (int i = 0; i < L1; i++) ch.push_back(8'd0);
  endtask

  // Records expectations for the current cycle and drives this cycle's colour.
  task automatic do_cycle(logic sof_e);
    exp_t e;
    e.px  = 11'(hx);
    e.py  = 11'(vy);
    e.sof = sof_e;
    e.fc  = fc;
    e.v0  = dq0.pop_front();
    e.v1  = dq1.pop_front();
    dq0.push_back(e_of(hx, vy));
    dq1.push_back(e_of(hx, vy));
    sq.push_back(e);
    -> ev_cyc;
    rgb0 = col(hx, vy);
    ch.push_back(col(hx, vy));
    rgb1 = ch.pop_front();
  endtask

  task automatic step();
    logic s;
    @(posedge clk);
    #1;
    hx++;
    if (hx == HT) begin
      hx = 0;
      vy++;
      if (vy == VT) vy = 0;
    end
    s = (hx == 0) && (vy == VA);
    if (s) fc = fc + 16'd1;
    do_cycle(s);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    push_reset_exp();
    repeat (3) @(posedge clk);
    #1;
    push_reset_exp();
    @(negedge clk);
    resetN = 1'b1;
    #1;
    start_after_reset();
    do_cycle(1'b0);
  endtask

  initial begin
    resetN = 1'b0;
    rgb0   = 8'd0;
    rgb1   = 8'd0;
    hx     = 0;
    vy     = 0;
    fc     = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    push_reset_exp();
    @(negedge clk);
    resetN = 1'b1;
    #1;
    start_after_reset();
    do_cycle(1'b0);

    // Two full frames plus margin: two startOfFrame pulses expected.
    repeat (2 * FT + 10) step();

    // Counter wrap: preload 0xFFFF, next frame start must roll to 0.
    @(negedge clk);
    force dut0.r_frame_cnt = 16'hFFFF;
    force dut1.r_frame_cnt = 16'hFFFF;
    #1;
    release dut0.r_frame_cnt;
    release dut1.r_frame_cnt;
    fc = 16'hFFFF;
    repeat (FT) step();

    // Mid-frame asynchronous reset, then restart from (0,0).
    while (!(hx == 7 && vy == 5)) step();
    reset_pulse();
    repeat (FT + 60) step();

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
